// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
//   arb_state_e : arbiter sequencing state (idle, fetch on bus, data on bus, hung-bus error)
//   gnt_src_e   : which requester, if any, wins arbitration in the current idle cycle
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StData  = 2'd2,
    StError = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GntNone  = 2'd0,
    GntFetch = 2'd1,
    GntData  = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/bus_watchdog.sv
// Hung-bus watchdog for the memory-port arbiter.
// Counts un-acknowledged bus cycles of the current transaction and raises a one-cycle
// timeout pulse in the cycle that makes the count reach TIMEOUT. TIMEOUT = 0 disables it.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   clear    : new transaction granted; restart the count
//   active   : bus transaction in flight and not acknowledged this cycle
//   timeout  : this cycle is the TIMEOUT-th un-acked cycle
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic active,
  output logic timeout
);

  // One extra bit so the compare cannot alias when the counter is near full scale.
  localparam logic [CNT_W:0] Limit  = (CNT_W + 1)'(TIMEOUT);
  localparam logic           Enable = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  assign timeout = Enable && active && !clear && (cnt_inc == Limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory bus between IF-stage fetch and MEM-stage load/store.
// Each granted request runs one valid/ack bus transaction; completion is reported with a
// one-cycle pulse one cycle after bus_ack. Data requests always win over fetches.
//   clk, reset_n                     : clock (rising edge), asynchronous active-low reset
//   if_req/if_addr/if_flush          : fetch request, address, redirect kill
//   if_valid/if_rdata                : fetch completion pulse and instruction
//   mem_req/mem_we/mem_addr/mem_wdata: load/store request
//   mem_done/mem_rdata               : data completion pulse and load data
//   stall_fetch/stall_mem            : requester still waiting (combinational)
//   bus_req/bus_we/bus_addr/bus_wdata: bus transaction outputs, held until bus_ack
//   bus_ack/bus_rdata                : bus completion and read data
//   bus_error                        : sticky watchdog error, cleared only by reset
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_error
);

  arb_state_e state_q;
  logic       kill_q;
  gnt_src_e   grant;
  logic       mem_elig, if_elig;
  logic       busy;
  logic       wd_clear, wd_active, wd_timeout;

  // A request is masked in the cycle its own completion pulse is high, so a requester that
  // still holds req in that cycle is not granted a second transaction.
  assign mem_elig = mem_req & ~mem_done;
  assign if_elig  = if_req & ~if_valid & ~if_flush;

  // Data wins: the MEM-stage instruction is older than the one being fetched.
  always_comb begin
    grant = GntNone;
    if (state_q == StIdle) begin
      if (mem_elig) begin
        grant = GntData;
      end else if (if_elig) begin
        grant = GntFetch;
      end
    end
  end

  assign busy      = (state_q == StFetch) || (state_q == StData);
  assign wd_clear  = (grant != GntNone);
  assign wd_active = busy & ~bus_ack;

  assign stall_fetch = if_req & ~if_valid;
  assign stall_mem   = mem_req & ~mem_done;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_bus_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .active  (wd_active),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      kill_q    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      bus_error <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses.
      if_valid <= 1'b0;
      mem_done <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant == GntData) begin
            state_q   <= StData;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (grant == GntFetch) begin
            state_q   <= StFetch;
            kill_q    <= 1'b0;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end

        StFetch: begin
          // A redirect cannot abort the bus cycle; it only hides the result from IF.
          if (if_flush) begin
            kill_q <= 1'b1;
          end
          if (bus_ack) begin
            state_q <= StIdle;
            bus_req <= 1'b0;
            kill_q  <= 1'b0;
            if (!kill_q && !if_flush) begin
              if_valid <= 1'b1;
              if_rdata <= bus_rdata;
            end
          end else if (wd_timeout) begin
            state_q   <= StError;
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            kill_q    <= 1'b0;
          end
        end

        StData: begin
          if (bus_ack) begin
            state_q   <= StIdle;
            bus_req   <= 1'b0;
            mem_done  <= 1'b1;
            mem_rdata <= bus_rdata;
          end else if (wd_timeout) begin
            state_q   <= StError;
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
          end
        end

        StError: begin
          // Terminal until reset; no pulses, so both requesters stay stalled.
          bus_req   <= 1'b0;
          bus_error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        if_valid, mem_done, stall_fetch, stall_mem;
  logic        bus_req, bus_we, bus_error;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;

  mem_port_arbiter #(
    .TIMEOUT (TO),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_valid    (if_valid),
    .if_rdata    (if_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .stall_fetch (stall_fetch),
    .stall_mem   (stall_mem),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_error   (bus_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'd7) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Transaction-level view: one outstanding bus transaction at most, one completion pulse
  // the cycle after its ack, a sticky error after TO un-acked cycles.
  logic        m_busy = 0, m_data = 0, m_killed = 0, m_err = 0;
  int          m_wait = 0;
  logic        e_if_valid = 0, e_mem_done = 0, e_bus_req = 0, e_bus_we = 0;
  logic [31:0] e_if_rdata = '0, e_mem_rdata = '0, e_bus_addr = '0, e_bus_wdata = '0;
  logic        was_if, was_mem;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 0; m_data = 0; m_killed = 0; m_err = 0; m_wait = 0;
        e_if_valid = 0; e_mem_done = 0; e_bus_req = 0; e_bus_we = 0;
        e_if_rdata = '0; e_mem_rdata = '0; e_bus_addr = '0; e_bus_wdata = '0;
      end else begin
        was_if = e_if_valid;
        was_mem = e_mem_done;
        e_if_valid = 0;
        e_mem_done = 0;
        if (m_err) begin
          // stuck until reset
        end else if (m_busy) begin
          if (!m_data && if_flush) m_killed = 1;
          if (bus_ack) begin
            m_busy = 0;
            if (m_data) begin
              e_mem_done = 1; e_mem_rdata = bus_rdata;
            end else if (!m_killed) begin
              e_if_valid = 1; e_if_rdata = bus_rdata;
            end
          end else begin
            m_wait++;
            if (TO != 0 && m_wait == int'(TO)) begin
              m_err = 1; m_busy = 0;
            end
          end
        end else if (mem_req && !was_mem) begin
          m_busy = 1; m_data = 1; m_wait = 0;
          e_bus_addr = mem_addr; e_bus_we = mem_we; e_bus_wdata = mem_wdata;
        end else if (if_req && !was_if && !if_flush) begin
          m_busy = 1; m_data = 0; m_killed = 0; m_wait = 0;
          e_bus_addr = if_addr; e_bus_we = 0;
        end
        e_bus_req = m_busy;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check1("bus_req", bus_req, e_bus_req);
      check1("bus_error", bus_error, m_err);
      check1("if_valid", if_valid, e_if_valid);
      check1("mem_done", mem_done, e_mem_done);
      check("if_rdata", if_rdata, e_if_rdata);
      check("mem_rdata", mem_rdata, e_mem_rdata);
      check1("stall_fetch", stall_fetch, if_req & ~e_if_valid);
      check1("stall_mem", stall_mem, mem_req & ~e_mem_done);
      if (e_bus_req) begin
        check("bus_addr", bus_addr, e_bus_addr);
        check1("bus_we", bus_we, e_bus_we);
        if (e_bus_we) check("bus_wdata", bus_wdata, e_bus_wdata);
      end
    end
  end

  // ---------------- bus responder and transaction monitor ----------------
  int ack_wait = 0;
  bit rand_ack = 0;
  int wcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rand_ack) begin
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom();
      end else if (bus_req) begin
        if (wcnt >= ack_wait) begin
          bus_ack = 1'b1; bus_rdata = resp_data(bus_addr); wcnt = 0;
        end else begin
          bus_ack = 1'b0; wcnt++;
        end
      end else begin
        bus_ack = 1'b0; wcnt = 0;
      end
    end
  end

  int   n_txn = 0;
  logic prev_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) n_txn++;
      prev_req = bus_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input bit is_mem, input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = is_mem ? mem_done : if_valid;
    end
    check1(name, seen, 1'b1);
  endtask

  int base;

  initial begin
    // Reset state
    tick();
    tick();
    check1("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check1("rst_bus_error", bus_error, 1'b0);
    check1("rst_stall_fetch", stall_fetch, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1. zero-wait fetch
    ack_wait = 0;
    if_req = 1; if_addr = 32'h100;
    #1;
    check1("t1_stall_c0", stall_fetch, 1'b1);
    tick();
    check1("t1_bus_req_c1", bus_req, 1'b1);
    check("t1_bus_addr", bus_addr, 32'h100);
    check1("t1_bus_we", bus_we, 1'b0);
    check1("t1_stall_c1", stall_fetch, 1'b1);
    tick();
    check1("t1_if_valid_c2", if_valid, 1'b1);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check1("t1_stall_c2", stall_fetch, 1'b0);
    check("t1_model_if_rdata", e_if_rdata, 32'h0050_0093);
    if_req = 0;
    tick();
    tick();

    // 2. collision: store wins, then fetch
    base = n_txn;
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
    tick();
    check1("t2_bus_we", bus_we, 1'b1);
    check("t2_bus_addr", bus_addr, 32'h2000);
    check("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    tick();
    check1("t2_mem_done", mem_done, 1'b1);
    check1("t2_if_wait", if_valid, 1'b0);
    mem_req = 0; mem_we = 0;
    tick();
    check("t2_fetch_addr", bus_addr, 32'h104);
    check1("t2_fetch_we", bus_we, 1'b0);
    wait_pulse(0, 10, "t2_if_valid");
    if_req = 0;
    repeat (3) tick();
    check("t2_txn_count", 32'(n_txn - base), 32'd2);

    // 3. flush mid-fetch, 3 wait states
    ack_wait = 3;
    if_req = 1; if_addr = 32'h300;
    tick();
    check("t3_bus_addr", bus_addr, 32'h300);
    tick();
    if_flush = 1; if_addr = 32'h200;
    tick();
    if_flush = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check1("t3_no_if_valid", if_valid, 1'b0);
    end
    check1("t3_refetch_req", bus_req, 1'b1);
    check("t3_refetch_addr", bus_addr, 32'h200);
    wait_pulse(0, 20, "t3_if_valid");
    check("t3_if_rdata", if_rdata, resp_data(32'h200));
    if_req = 0;
    ack_wait = 0;
    tick();

    // 4. timeout on a load
    ack_wait = 1000;
    mem_req = 1; mem_we = 0; mem_addr = 32'h40;
    for (int k = 0; k < int'(TO); k++) begin
      tick();
      check1("t4_bus_req_wait", bus_req, 1'b1);
      check1("t4_no_error_yet", bus_error, 1'b0);
    end
    tick();
    check1("t4_bus_error", bus_error, 1'b1);
    check1("t4_bus_req_low", bus_req, 1'b0);
    check1("t4_stall_mem", stall_mem, 1'b1);
    check1("t4_model_err", m_err, 1'b1);
    for (int k = 0; k < 100; k++) begin
      tick();
      check1("t4_sticky", bus_error & stall_mem & ~bus_req & ~mem_done, 1'b1);
    end
    mem_req = 0;
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    check1("t4_error_cleared", bus_error, 1'b0);
    ack_wait = 0;

    // 5. asynchronous reset during a waited data transaction
    ack_wait = 5;
    mem_req = 1; mem_we = 0; mem_addr = 32'h80;
    tick();
    tick();
    check1("t5_bus_req", bus_req, 1'b1);
    #2;
    reset_n = 0;
    #1;
    check1("t5_async_bus_req", bus_req, 1'b0);
    check("t5_async_bus_addr", bus_addr, 32'h0);
    check("t5_async_if_rdata", if_rdata, 32'h0);
    check("t5_async_mem_rdata", mem_rdata, 32'h0);
    mem_req = 0;
    tick();
    reset_n = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check1("t5_no_mem_done", mem_done, 1'b0);
    end
    ack_wait = 0;
    mem_req = 1; mem_addr = 32'h84;
    wait_pulse(1, 10, "t5_fresh_done");
    check("t5_fresh_rdata", mem_rdata, resp_data(32'h84));
    mem_req = 0;
    tick();

    // 6. done masking with req held through the done cycle
    ack_wait = 1;
    base = n_txn;
    mem_req = 1; mem_we = 0; mem_addr = 32'h10;
    wait_pulse(1, 10, "t6_done0");
    check("t6_rdata0", mem_rdata, resp_data(32'h10));
    tick();
    mem_addr = 32'h14;
    wait_pulse(1, 10, "t6_done1");
    check("t6_rdata1", mem_rdata, resp_data(32'h14));
    mem_req = 0;
    repeat (3) tick();
    check("t6_txn_count", 32'(n_txn - base), 32'd2);
    ack_wait = 0;

    // Randomized traffic against the model
    rand_ack = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus_error || m_err) begin
        if_req = 0; mem_req = 0; if_flush = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
      end else begin
        if (if_valid) begin
          if_req = 1'($urandom_range(0, 1));
          if_addr = $urandom() & 32'hFFFF_FFFC;
        end else if (!if_req && $urandom_range(0, 3) == 0) begin
          if_req = 1;
          if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if_flush = ($urandom_range(0, 7) == 0);
        if (if_flush && if_req && $urandom_range(0, 1) == 1) if_addr = $urandom() & 32'hFFFF_FFFC;
        if (mem_done) begin
          mem_req = 1'($urandom_range(0, 1));
          mem_we = 1'($urandom_range(0, 1));
          mem_addr = $urandom() & 32'hFFFF_FFFC;
          mem_wdata = $urandom();
        end else if (!mem_req && $urandom_range(0, 3) == 0) begin
          mem_req = 1;
          mem_we = 1'($urandom_range(0, 1));
          mem_addr = $urandom() & 32'hFFFF_FFFC;
          mem_wdata = $urandom();
        end
      end
    end
    rand_ack = 0;
    if_req = 0; mem_req = 0; if_flush = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
